mips_fetch_queue: RTL and testbench
===================================

Name: mips_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the next-generation MIPS core; replaces the single-cycle PC register and PC+4 adder path.
- Owns the fetch PC and issues in-order requests to an instruction memory with variable latency.
- Buffers returned instructions, each tagged with its PC, in a FIFO feeding decode through a valid/ready handshake.
- Accepts branch/jump redirects from execute; on a redirect it flushes the queue and discards stale in-flight responses.

Parameters:
- ADDR_W, 32, width of all PC/address fields.
- RESET_PC, 32'h0000_0000, fetch PC after reset. Must be word aligned.
- FQ_DEPTH, 4, instruction queue entries. Also the credit limit on requests. Legal range 2..16.
- CNT_W, 5, width of the outstanding/discard/occupancy counters. Must hold FQ_DEPTH.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to clk.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  ADDR_W  fetch address; always word aligned.
- imem_gnt_i  input  1  memory accepts the request this cycle.
- imem_rvalid_i  input  1  response valid. Responses return in request order, at least 1 cycle after grant.
- imem_rdata_i  input  32  returned instruction.
- redirect_i  input  1  branch/jump taken; load a new fetch PC.
- redirect_pc_i  input  ADDR_W  redirect target; bits [1:0] are ignored and treated as 0.
- instr_valid_o  output  1  queue head valid toward decode.
- instr_o  output  32  instruction at queue head.
- instr_pc_o  output  ADDR_W  PC of instr_o.
- instr_ready_i  input  1  decode consumes the head this cycle.
- fq_count_o  output  CNT_W  current queue occupancy.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC, resp_pc = RESET_PC.
  - Queue empty; outstanding = 0; discard = 0.
  - imem_req_o = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, fq_count_o = 0.
- Request issue:
  - imem_req_o = ~redirect_i & (outstanding + fq_count < FQ_DEPTH).
  - imem_addr_o = fetch_pc.
  - On req & gnt: fetch_pc += 4 (wraps modulo 2^ADDR_W) and outstanding += 1.
  - imem_addr_o and imem_req_o stay stable while the request waits for a grant.
- Response handling (imem_rvalid_i):
  - outstanding -= 1.
  - If discard > 0: drop the data and decrement discard.
  - Otherwise push {imem_rdata_i, resp_pc} into the queue and advance resp_pc by 4.
- Credit accounting:
  - outstanding counts both live and to-be-discarded requests.
  - Credit checking guarantees a push never finds the queue full. A push into a full queue is an assertion failure.
- Dequeue: instr_valid_o = queue not empty. On instr_valid_o & instr_ready_i, pop the head.
- Same-cycle push and pop: both take effect; occupancy is unchanged. Queue pointers wrap at FQ_DEPTH-1 (non-power-of-2 depths are supported).
- Redirect (redirect_i = 1), all effective at the next edge:
  - Queue flushed, including any pop in the same cycle (pop has no effect).
  - fetch_pc <= {redirect_pc_i[ADDR_W-1:2], 2'b00}; resp_pc loaded with the same value.
  - discard <= (outstanding + discard counting already folded in) − (1 if imem_rvalid_i this cycle). The response arriving in the redirect cycle is always dropped.
  - No request is issued in the redirect cycle.
- Back-to-back redirects: the last one wins. discard accumulates correctly because it tracks outstanding.
- Reset mid-operation: all counters and the queue are cleared. Responses for pre-reset requests are the memory's responsibility and must not arrive after reset.

Optional Feature:
- Macro: MIPS_FETCH_BYPASS_EN.
- Defined:
  - When the queue is empty, discard = 0, no redirect is active and imem_rvalid_i is high, the response is presented combinationally on instr_o/instr_pc_o with instr_valid_o = 1 in the same cycle.
  - If instr_ready_i is also high, the entry is not written to the queue.
  - Zero-cycle fetch-to-decode latency.
- Undefined: every response is registered into the queue; instr_valid_o rises 1 cycle after imem_rvalid_i at the earliest.

Test Plan:
- Reset release, memory with 1-cycle latency, gnt=1, ready=1 → addresses 0x0,0x4,0x8,...; instr_pc_o follows 0x0,0x4,0x8; without bypass the first instr_valid_o comes 2 cycles after the first grant.
- ready=0 held, FQ_DEPTH=4 → exactly 4 grants, then imem_req_o=0; fq_count_o=4. Pulse ready for 1 cycle → exactly one new request issues.
- 3 requests outstanding (3-cycle latency), redirect to 0x100 → next address is 0x100. The 3 stale responses are dropped; the first instr_pc_o after the redirect is 0x100.
- Redirect in the same cycle as imem_rvalid_i and instr_ready_i with 2 entries queued → queue empties, the response is dropped, fq_count_o=0 next cycle.
- redirect_pc_i=0x203 → imem_addr_o=0x200. fetch_pc at 0xFFFF_FFFC rolls over to 0x0.
- With MIPS_FETCH_BYPASS_EN, queue empty, rvalid with data 0x2408_0005 and ready=1 → instr_valid_o and instr_o=0x2408_0005 in the same cycle; fq_count_o stays 0.

Source files
------------

// File: rtl/mips_fetch_queue.sv
// MIPS fetch front end: fetch PC, credit-limited imem requests, tagged FIFO.
// Optional MIPS_FETCH_BYPASS_EN: empty-queue responses go straight to decode.
module mips_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                FQ_DEPTH = 4,
  parameter int                CNT_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i,
  output logic [CNT_W-1:0]  fq_count_o
);

  localparam int PTR_W =
    (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST =
    PTR_W'(FQ_DEPTH - 1);
  localparam logic [CNT_W:0] DEPTH_C =
    (CNT_W + 1)'(FQ_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C =
    CNT_W'(FQ_DEPTH);
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_M =
    ~ADDR_W'(3);

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } fq_entry_t;

  fq_entry_t         fq_mem [FQ_DEPTH];
  fq_entry_t         head;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] tgt_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  out_nxt;
  logic [CNT_W-1:0]  out_rv;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W:0]    credit_used;

  logic credit_ok;
  logic req;
  logic fire;
  logic accept;
  logic drop;
  logic empty;
  logic full;
  logic head_valid;
  logic push;
  logic pop;

  // request credit, response classification and counter next values
  always_comb begin
    credit_used = {1'b0, outstanding}
                + {1'b0, count};
    credit_ok   = credit_used < DEPTH_C;
    req         = reset & ~redirect_i & credit_ok;
    fire        = req & imem_gnt_i;
    accept      = imem_rvalid_i & ~redirect_i
                & (discard == '0);
    drop        = imem_rvalid_i & ~redirect_i
                & (discard != '0);
    empty       = count == '0;
    full        = count == FULL_C;
    tgt_pc      = redirect_pc_i & ALIGN_M;
    out_rv      = outstanding
                - CNT_W'(imem_rvalid_i);
    out_nxt     = out_rv + CNT_W'(fire);
  end

`ifdef MIPS_FETCH_BYPASS_EN
  logic byp;

  // head selection with empty-queue bypass of the live response
  always_comb begin
    byp        = accept & empty;
    head_valid = ~empty | byp;
    head       = empty ? {imem_rdata_i, resp_pc}
                       : fq_mem[rd_ptr];
    push       = accept & ~(byp & instr_ready_i);
    pop        = ~empty & instr_ready_i & ~redirect_i;
  end
`else
  // head selection straight from the queue
  always_comb begin
    head_valid = ~empty;
    head       = fq_mem[rd_ptr];
    push       = accept;
    pop        = ~empty & instr_ready_i & ~redirect_i;
  end
`endif

  // drive outputs; payload is zero while nothing is valid
  always_comb begin
    imem_req_o    = req;
    imem_addr_o   = fetch_pc;
    instr_valid_o = head_valid;
    instr_o       = head_valid ? head.instr : '0;
    instr_pc_o    = head_valid ? head.pc : '0;
    fq_count_o    = count;
  end

  // fetch PC: redirect target or advance on granted request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else begin
      unique case (1'b1)
        redirect_i: fetch_pc <= tgt_pc;
        fire:       fetch_pc <= fetch_pc + STEP;
        default:    fetch_pc <= fetch_pc;
      endcase
    end
  end

  // response PC tag follows accepted responses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_pc <= RESET_PC;
    end else begin
      unique case (1'b1)
        redirect_i: resp_pc <= tgt_pc;
        accept:     resp_pc <= resp_pc + STEP;
        default:    resp_pc <= resp_pc;
      endcase
    end
  end

  // in-flight count; redirect marks every survivor as stale
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= out_nxt;
      unique case (1'b1)
        redirect_i: discard <= out_rv;
        drop:       discard <= discard - 1'b1;
        default:    discard <= discard;
      endcase
    end
  end

  // queue pointers and occupancy; redirect flushes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == LAST) ? '0
                : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == LAST) ? '0
                : rd_ptr + 1'b1;
      count <= count + CNT_W'(push)
             - CNT_W'(pop);
    end
  end

  // queue storage; contents are masked until valid
  always_ff @(posedge clk) begin
    if (push)
      fq_mem[wr_ptr] <= {imem_rdata_i, resp_pc};
  end

  // credit accounting must never let a push hit a full queue
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset)
    !(push && full)
  );

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: in-order latency memory plus scoreboard.
// Builds with or without MIPS_FETCH_BYPASS_EN.
module tb_mips_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [4:0]  fq_count_o;

  mips_fetch_queue #(
    .ADDR_W(32), .RESET_PC(32'h0),
    .FQ_DEPTH(4), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_o(instr_o),
    .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i),
    .fq_count_o(fq_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] eaddr;
    int          epoch;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  pend_t       pending[$];
  pend_t       cur;
  exp_t        expq[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          epoch = 0;
  int          grants = 0;
  int          first_grant = -1;
  int          first_valid = -1;
  logic [31:0] exp_addr = 32'h0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h300) return 32'h2408_0005;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // observe one cycle just before the edge that acts on it
  task automatic monitor();
    if (imem_rvalid_i && cur.epoch == epoch && !redirect_i)
      expq.push_back('{mem_data(cur.eaddr), cur.eaddr});
    if (instr_valid_o && first_valid < 0)
      first_valid = cyc;
    if (instr_valid_o && instr_ready_i && !redirect_i) begin
      if (expq.size() == 0) begin
        check("pop_unexpected", 64'(expq.size()), 64'd1);
      end else begin
        e = expq.pop_front();
        check("pop_instr", instr_o, e.instr);
        check("pop_pc", instr_pc_o, e.pc);
      end
    end
    if (redirect_i) begin
      check("req_in_redirect", imem_req_o, 0);
      epoch++;
      exp_addr = redirect_pc_i & ~32'h3;
      expq.delete();
    end else if (imem_req_o && imem_gnt_i) begin
      check("req_addr", imem_addr_o, exp_addr);
      pending.push_back('{imem_addr_o, exp_addr, epoch, cyc + lat});
      exp_addr = exp_addr + 32'd4;
      grants++;
      if (first_grant < 0) first_grant = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (reset && pending.size() > 0 && pending[0].due <= cyc) begin
      cur = pending.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_data(cur.addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  endtask

  task automatic drain(input int n);
    imem_gnt_i    = 1'b0;
    instr_ready_i = 1'b1;
    repeat (n) tick();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    tick();
    redirect_i    = 1'b0;
  endtask

  task automatic wait_valid(input int maxc);
    for (int i = 0; i < maxc && !instr_valid_o; i++) tick();
    check("wait_valid", instr_valid_o, 1);
  endtask

  initial begin
    reset         = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
    tick();
    tick();
    check("rst_req", imem_req_o, 0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", instr_valid_o, 0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", instr_pc_o, 32'h0);
    check("rst_count", fq_count_o, 5'd0);

    // streaming, 1-cycle memory
    reset         = 1'b1;
    imem_gnt_i    = 1'b1;
    instr_ready_i = 1'b1;
    repeat (12) tick();
`ifdef MIPS_FETCH_BYPASS_EN
    check("first_latency", 64'(first_valid - first_grant), 64'd1);
`else
    check("first_latency", 64'(first_valid - first_grant), 64'd2);
`endif
    drain(6);

    // credit limit with decode stalled
    redirect_to(32'h1000);
    instr_ready_i = 1'b0;
    imem_gnt_i    = 1'b1;
    grants        = 0;
    repeat (10) tick();
    check("stall_grants", 64'(grants), 64'd4);
    check("stall_req", imem_req_o, 0);
    check("stall_count", fq_count_o, 5'd4);
    grants        = 0;
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    repeat (6) tick();
    check("pulse_grants", 64'(grants), 64'd1);
    check("pulse_count", fq_count_o, 5'd4);
    drain(8);
    check("drain_count", fq_count_o, 5'd0);

    // redirect with three stale requests in flight
    redirect_to(32'h2000);
    lat           = 3;
    imem_gnt_i    = 1'b1;
    instr_ready_i = 1'b1;
    repeat (3) tick();
    redirect_to(32'h100);
    check("redir_addr", imem_addr_o, 32'h100);
    wait_valid(10);
    check("redir_first_pc", instr_pc_o, 32'h100);
    check("redir_first_instr", instr_o, mem_data(32'h100));
    drain(10);
    lat = 1;

    // redirect colliding with response and pop
    redirect_to(32'h500);
    instr_ready_i = 1'b0;
    imem_gnt_i    = 1'b1;
    repeat (3) tick();
    imem_gnt_i    = 1'b0;
    check("coll_pre_count", fq_count_o, 5'd2);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h400;
    instr_ready_i = 1'b1;
    tick();
    redirect_i    = 1'b0;
    check("coll_count", fq_count_o, 5'd0);
    check("coll_valid", instr_valid_o, 0);
    drain(4);
    check("coll_after_count", fq_count_o, 5'd0);

    // unaligned target and address wrap
    redirect_to(32'h203);
    check("align_addr", imem_addr_o, 32'h200);
    redirect_to(32'hFFFF_FFF8);
    imem_gnt_i    = 1'b1;
    instr_ready_i = 1'b1;
    tick();
    check("wrap_pre_addr", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr", imem_addr_o, 32'h0);
    repeat (4) tick();
    drain(6);

    // empty-queue response timing
    redirect_to(32'h300);
    imem_gnt_i    = 1'b1;
    instr_ready_i = 1'b1;
    tick();
    imem_gnt_i    = 1'b0;
`ifdef MIPS_FETCH_BYPASS_EN
    check("byp_valid", instr_valid_o, 1);
    check("byp_instr", instr_o, 32'h2408_0005);
    check("byp_pc", instr_pc_o, 32'h300);
    check("byp_count", fq_count_o, 5'd0);
    tick();
    check("byp_count_next", fq_count_o, 5'd0);
`else
    check("nobyp_valid", instr_valid_o, 0);
    tick();
    check("nobyp_valid_next", instr_valid_o, 1);
    check("nobyp_instr", instr_o, 32'h2408_0005);
`endif
    drain(6);
    check("sb_left", 64'(expq.size()), 64'd0);
    check("mem_left", 64'(pending.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
